pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipelined RV32I core.
- Consumes decode-stage control (halt, register usage), ID/EX load information and the EX-stage redirect.
- Drives PC and IF/ID write enables and the per-register flush/bubble strobes.
- Owns the halt sequence (ECALL/EBREAK/FENCE): drains the pipeline, then freezes fetch.
- Sits beside the main decoder in ID and feeds the pipeline registers directly.

Parameters:
REG_ADDR_W, 5, register index width
DRAIN_CYCLES, 3, cycles after halt leaves ID until the pipeline is empty (EX, MEM, WB)
CNT_W, 32, performance counter width (optional feature only)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous active-high reset
ifid_rs1  in  REG_ADDR_W  rs1 field of the instruction in ID
ifid_rs2  in  REG_ADDR_W  rs2 field of the instruction in ID
ifid_uses_rs1  in  1  ID instruction reads rs1
ifid_uses_rs2  in  1  ID instruction reads rs2
id_halt  in  1  decoder halt flag for the ID instruction
idex_mem_read  in  1  instruction in EX is a load
idex_rd  in  REG_ADDR_W  destination register of the EX instruction
ex_redirect  in  1  taken branch, JAL or JALR resolved in EX
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID insert NOP
idex_flush  out  1  ID/EX insert bubble (all control bits zero)
halted  out  1  core stopped; pipeline empty
state_o  out  2  current FSM state (debug)

Behaviour:
- FSM states: RUN=0, DRAIN=1, HALTED=2. Encoding lives in the package.
- Reset values: state=RUN, drain counter=0, halted=0.
- During the cycle rst is high, all strobes and enables (pc_write, ifid_write, ifid_flush, idex_flush) are forced to 0.
- Strobes are combinational from the current state and inputs. State and counter update on the clk rising edge.
- Load-use condition: load_use = idex_mem_read && idex_rd!=0 && ((ifid_uses_rs1 && ifid_rs1==idex_rd) || (ifid_uses_rs2 && ifid_rs2==idex_rd)).
- RUN, priority order:
  1. ex_redirect: ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1. Any id_halt or load_use in the same cycle is discarded, because the ID instruction is wrong-path. Stay in RUN.
  2. load_use: pc_write=0, ifid_write=0, idex_flush=1, for exactly one cycle. The next cycle re-evaluates, which normally clears because the load has advanced.
  3. id_halt: pc_write=0, ifid_write=1, ifid_flush=1, so the halt instruction moves to EX and no newer instruction follows it. Next state DRAIN, counter loaded with DRAIN_CYCLES-1.
  4. Otherwise: pc_write=1, ifid_write=1, no flushes.
- DRAIN:
  - pc_write=0, ifid_write=1, ifid_flush=1, idex_flush=1.
  - ex_redirect is ignored; no instruction older than the halt can be in EX.
  - The counter decrements each cycle. When it reaches 0, next state is HALTED.
- HALTED:
  - halted=1, pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=0.
  - Only rst leaves this state.
- Reset mid-DRAIN or in HALTED returns to RUN on the next edge; no residual strobes.
- A halt in ID while a load_use is pending: the stall wins and the halt is accepted in a later cycle. No double halt entry.

Optional Feature:
HAZARD_PERF_CNT_EN:
- When defined, adds outputs stall_cnt, flush_cnt and cycle_cnt, each CNT_W bits, all cleared by rst.
- stall_cnt increments in each RUN cycle where load_use applies (priority 2). flush_cnt increments in each RUN cycle with ex_redirect. cycle_cnt increments every cycle while not HALTED.
- All counters wrap modulo 2^CNT_W and freeze in HALTED.
- When not defined, these ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - the FSM state localparams (RUN/DRAIN/HALTED), 2 bits;
  - REG_ADDR_W;
  - the x0 constant;
  - the opcode[6:2] values for HALT-class instructions (5'b11100, 5'b00011), for use by the decoder and the bench.
- One natural sub-module, hazard_load_use_det: the purely combinational load_use compare.
- The FSM, drain counter and optional counters stay in the top module.

Test Plan:
- Reset: after rst=1 for 2 cycles, then 0 → state_o=0, halted=0, pc_write=1, ifid_write=1, both flushes 0.
- Load-use: idex_mem_read=1, idex_rd=5, ifid_rs1=5, uses_rs1=1 → exactly one cycle with pc_write=0, ifid_write=0, idex_flush=1. Repeat with idex_rd=0 → no stall.
- Redirect: ex_redirect=1 with load_use and id_halt also 1 → ifid_flush=1, idex_flush=1, pc_write=1, state stays RUN.
- Halt: id_halt pulse in RUN → DRAIN for 3 cycles (flushes asserted, pc_write=0), then halted=1, state_o=2. ex_redirect=1 during DRAIN changes nothing.
- Reset during DRAIN (cycle 2) → RUN next edge, halted=0, all counters 0 if HAZARD_PERF_CNT_EN is defined.
- HAZARD_PERF_CNT_EN defined: 2 load-use stalls, 1 redirect, then halt → stall_cnt=2, flush_cnt=1, cycle_cnt frozen once halted.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and its users.
// Contents: FSM state encoding, register-index width, the x0 index and the
// opcode[6:2] values of the HALT-class instructions (SYSTEM, MISC-MEM).
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } hz_state_t;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  // opcode[6:2] of ECALL/EBREAK (SYSTEM) and FENCE (MISC-MEM)
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the ID/EX pipeline logic and the hazard controller.
// master: pipeline side, drives decode/EX information, receives enables/strobes.
// slave : hazard controller, receives decode/EX information, drives enables/strobes.
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] ifid_rs1;
  logic [REG_ADDR_W-1:0] ifid_rs2;
  logic                  ifid_uses_rs1;
  logic                  ifid_uses_rs2;
  logic                  id_halt;
  logic                  idex_mem_read;
  logic [REG_ADDR_W-1:0] idex_rd;
  logic                  ex_redirect;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  halted;
  logic [1:0]            state_o;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, id_halt,
           idex_mem_read, idex_rd, ex_redirect,
    input  pc_write, ifid_write, ifid_flush, idex_flush, halted, state_o
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, id_halt,
           idex_mem_read, idex_rd, ex_redirect,
    output pc_write, ifid_write, ifid_flush, idex_flush, halted, state_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_det.sv
// hazard_load_use_det: combinational load-use detector.
// Ports: i_ifid_rs1/i_ifid_rs2 + i_uses_rs1/i_uses_rs2 (ID operands),
//        i_idex_mem_read/i_idex_rd (load in EX), o_load_use (stall needed).
module hazard_load_use_det
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_ifid_rs1,
  input  logic [REG_ADDR_W-1:0] i_ifid_rs2,
  input  logic                  i_uses_rs1,
  input  logic                  i_uses_rs2,
  input  logic                  i_idex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_idex_rd,
  output logic                  o_load_use
);
  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1  = i_uses_rs1 && (i_ifid_rs1 == i_idex_rd);
  assign w_hit_rs2  = i_uses_rs2 && (i_ifid_rs2 == i_idex_rd);
  // A load to x0 never produces a value, so it cannot create a dependency.
  assign o_load_use = i_idex_mem_read && (i_idex_rd != REG_X0) && (w_hit_rs1 || w_hit_rs2);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage RV32I core.
// Ports: clk, rst (sync, active-high); hz (slave modport) carrying ID/EX
//        hazard inputs and the pc_write/ifid_write/ifid_flush/idex_flush
//        strobes plus halted/state_o.
// Optional macro HAZARD_PERF_CNT_EN adds stall_cnt, flush_cnt, cycle_cnt.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      cycle_cnt
`endif
);
  localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  hz_state_t         r_state, w_state_nxt;
  logic [DCNT_W-1:0] r_dcnt, w_dcnt_nxt;
  logic              w_load_use;
  logic              w_pc_write, w_ifid_write, w_ifid_flush, w_idex_flush;
  logic              w_stall_evt, w_flush_evt;

  hazard_load_use_det u_lu (
    .i_ifid_rs1      (hz.ifid_rs1),
    .i_ifid_rs2      (hz.ifid_rs2),
    .i_uses_rs1      (hz.ifid_uses_rs1),
    .i_uses_rs2      (hz.ifid_uses_rs2),
    .i_idex_mem_read (hz.idex_mem_read),
    .i_idex_rd       (hz.idex_rd),
    .o_load_use      (w_load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dcnt_nxt   = r_dcnt;
    w_pc_write   = 1'b0;
    w_ifid_write = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_stall_evt  = 1'b0;
    w_flush_evt  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (hz.ex_redirect) begin
          // ID holds a wrong-path instruction: its halt/load-use are moot.
          w_pc_write   = 1'b1;
          w_ifid_write = 1'b1;
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
          w_flush_evt  = 1'b1;
        end else if (w_load_use) begin
          // Stall wins over halt; a halt in ID is retaken once the load moves on.
          w_idex_flush = 1'b1;
          w_stall_evt  = 1'b1;
        end else if (hz.id_halt) begin
          w_ifid_write = 1'b1;
          w_ifid_flush = 1'b1;
          w_state_nxt  = ST_DRAIN;
          w_dcnt_nxt   = DCNT_W'(DRAIN_CYCLES - 1);
        end else begin
          w_pc_write   = 1'b1;
          w_ifid_write = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Redirects are ignored: only the halt itself or younger can be in EX.
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
        if (r_dcnt == '0) w_state_nxt = ST_HALTED;
        else              w_dcnt_nxt  = r_dcnt - DCNT_W'(1);
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_dcnt_nxt  = '0;
      end
    endcase
    if (rst) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_ifid_flush = 1'b0;
      w_idex_flush = 1'b0;
    end
  end

  assign hz.pc_write   = w_pc_write;
  assign hz.ifid_write = w_ifid_write;
  assign hz.ifid_flush = w_ifid_flush;
  assign hz.idex_flush = w_idex_flush;
  assign hz.halted     = (r_state == ST_HALTED);
  assign hz.state_o    = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_cycle_cnt <= '0;
    end else if (r_state != ST_HALTED) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_stall_evt) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_evt) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign cycle_cnt = r_cycle_cnt;
`else
  logic w_unused_evt;
  assign w_unused_evt = w_stall_evt ^ w_flush_evt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int DRAIN = 3;
  localparam int CW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt, cycle_cnt;
`endif

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .cycle_cnt (cycle_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=run 1=drain 2=halted, plus drain cycles elapsed.
  int m_mode = 0;
  int m_since = 0;
  longint m_stall = 0, m_flush = 0, m_cycle = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit lu, e_pc, e_iw, e_if, e_xf;
      lu = hz.idex_mem_read && (hz.idex_rd != 0) &&
           ((hz.ifid_uses_rs1 && hz.ifid_rs1 == hz.idex_rd) ||
            (hz.ifid_uses_rs2 && hz.ifid_rs2 == hz.idex_rd));
      e_pc = 0; e_iw = 0; e_if = 0; e_xf = 0;
      if (!rst) begin
        if (m_mode == 0) begin
          if (hz.ex_redirect) begin e_pc = 1; e_iw = 1; e_if = 1; e_xf = 1; end
          else if (lu)        begin e_xf = 1; end
          else if (hz.id_halt) begin e_iw = 1; e_if = 1; end
          else                begin e_pc = 1; e_iw = 1; end
        end else if (m_mode == 1) begin
          e_iw = 1; e_if = 1; e_xf = 1;
        end
      end
      chk("m_pc_write",   hz.pc_write,   e_pc);
      chk("m_ifid_write", hz.ifid_write, e_iw);
      chk("m_ifid_flush", hz.ifid_flush, e_if);
      chk("m_idex_flush", hz.idex_flush, e_xf);
      chk("m_halted",     hz.halted,     m_mode == 2);
      chk("m_state",      hz.state_o,    m_mode);
`ifdef HAZARD_PERF_CNT_EN
      chk("m_stall_cnt", stall_cnt, m_stall[CW-1:0]);
      chk("m_flush_cnt", flush_cnt, m_flush[CW-1:0]);
      chk("m_cycle_cnt", cycle_cnt, m_cycle[CW-1:0]);
`endif
      // advance model across the coming rising edge
      if (rst) begin
        m_mode = 0; m_since = 0; m_stall = 0; m_flush = 0; m_cycle = 0;
      end else begin
        if (m_mode != 2) m_cycle++;
        if (m_mode == 0) begin
          if (hz.ex_redirect) m_flush++;
          else if (lu) m_stall++;
          else if (hz.id_halt) begin m_mode = 1; m_since = 0; end
        end else if (m_mode == 1) begin
          m_since++;
          if (m_since == DRAIN) m_mode = 2;
        end
      end
    end
  end

  task automatic drive(input bit mr, input int rd, input int rs1, input bit u1,
                       input int rs2, input bit u2, input bit halt, input bit redir);
    hz.idex_mem_read = mr;
    hz.idex_rd       = REG_ADDR_W'(rd);
    hz.ifid_rs1      = REG_ADDR_W'(rs1);
    hz.ifid_uses_rs1 = u1;
    hz.ifid_rs2      = REG_ADDR_W'(rs2);
    hz.ifid_uses_rs2 = u2;
    hz.id_halt       = halt;
    hz.ex_redirect   = redir;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    advance();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    advance();
    chk_en = 1'b1;
    // second reset cycle: everything forced low
    sample();
    chk("rst_pc_write", hz.pc_write, 1'b0);
    chk("rst_ifid_write", hz.ifid_write, 1'b0);
    advance();
    rst = 1'b0;
    sample();
    chk("rel_state", hz.state_o, 2'd0);
    chk("rel_halted", hz.halted, 1'b0);
    chk("rel_pc_write", hz.pc_write, 1'b1);
    chk("rel_ifid_write", hz.ifid_write, 1'b1);
    chk("rel_flushes", {hz.ifid_flush, hz.idex_flush}, 2'b00);
    advance();

    // load-use via rs1
    drive(1, 5, 5, 1, 0, 0, 0, 0);
    sample();
    chk("lu1_pc_write", hz.pc_write, 1'b0);
    chk("lu1_ifid_write", hz.ifid_write, 1'b0);
    chk("lu1_idex_flush", hz.idex_flush, 1'b1);
    advance();
    idle_cycle();
    // load-use via rs2
    drive(1, 7, 3, 1, 7, 1, 0, 0);
    sample();
    chk("lu2_pc_write", hz.pc_write, 1'b0);
    advance();
    // load to x0: no stall
    drive(1, 0, 0, 1, 0, 1, 0, 0);
    sample();
    chk("lu_x0_pc_write", hz.pc_write, 1'b1);
    chk("lu_x0_idex_flush", hz.idex_flush, 1'b0);
    advance();
    // matching rs1 but not used: no stall
    drive(1, 9, 9, 0, 4, 1, 0, 0);
    sample();
    chk("lu_unused_pc_write", hz.pc_write, 1'b1);
    advance();

    // redirect overrides load-use and halt
    drive(1, 5, 5, 1, 0, 0, 1, 1);
    sample();
    chk("redir_flushes", {hz.ifid_flush, hz.idex_flush}, 2'b11);
    chk("redir_pc_write", hz.pc_write, 1'b1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("redir_state_run", hz.state_o, 2'd0);
    advance();

    // halt: accepted this cycle, then three drain cycles
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    sample();
    chk("halt_ifid_flush", hz.ifid_flush, 1'b1);
    chk("halt_pc_write", hz.pc_write, 1'b0);
    advance();
    for (int i = 0; i < DRAIN; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, (i == 1));
      sample();
      chk("drain_state", hz.state_o, 2'd1);
      chk("drain_strobes", {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush}, 4'b0111);
      advance();
    end
    drive(1, 5, 5, 1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("halted_flag", hz.halted, 1'b1);
      chk("halted_state", hz.state_o, 2'd2);
      chk("halted_strobes", {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush}, 4'b0000);
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_stall_cnt", stall_cnt, 64'd2);
      chk("perf_flush_cnt", flush_cnt, 64'd1);
`endif
      advance();
    end

    // leave HALTED via reset
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("unhalt_state", hz.state_o, 2'd0);
    advance();

    // halt while load-use pending: stall first, halt accepted next cycle
    drive(1, 6, 6, 1, 0, 0, 1, 0);
    sample();
    chk("halt_lu_idex_flush", hz.idex_flush, 1'b1);
    chk("halt_lu_ifid_flush", hz.ifid_flush, 1'b0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    sample();
    chk("halt_lu_state_run", hz.state_o, 2'd0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("drain1_state", hz.state_o, 2'd1);
    advance();
    // reset in the second drain cycle
    rst = 1'b1;
    sample();
    chk("rst_drain_strobes", {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush}, 4'b0000);
    advance();
    rst = 1'b0;
    sample();
    chk("post_rst_state", hz.state_o, 2'd0);
    chk("post_rst_halted", hz.halted, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    chk("post_rst_cnts", {stall_cnt, flush_cnt, cycle_cnt}, '0);
`endif
    advance();
    idle_cycle();
    idle_cycle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
